// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - pipeline stall/flush arbiter with memory watchdog and perf counters
// Per-stage hold/bubble/flush strobes are Mealy outputs; state, flag and counters are registered.
module hazard_sequencer #(
    parameter int CNT_WIDTH  = 32,
    parameter int WAIT_LIMIT = 64
) (
    input  logic                 brq_clk,
    input  logic                 brq_rst_n,
    input  logic [1:0]           check_stall,
    input  logic                 idu_flush,
    input  logic                 ldst_req,
    input  logic                 ldst_resume,
    output logic                 pc_hold,
    output logic                 ifid_hold,
    output logic                 idex_hold,
    output logic                 exmem_hold,
    output logic                 idex_bubble,
    output logic                 ifid_flush,
    output logic [1:0]           hz_state,
    output logic                 hz_timeout,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_count
);

    localparam int WW = $clog2(WAIT_LIMIT);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_UNUSED   = 2'b10,
        ST_ERROR    = 2'b11
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [WW-1:0]         r_wait_cnt;
    logic [WW-1:0]         w_next_wait_cnt;
    logic                  r_timeout;
    logic [CNT_WIDTH-1:0]  r_stall_cycles;
    logic [CNT_WIDTH-1:0]  r_flush_count;

    logic w_hold_all;
    logic w_hold_front;
    logic w_bubble;
    logic w_flush;

    always_comb begin
        w_next_state    = r_state;
        w_next_wait_cnt = r_wait_cnt;
        w_hold_all      = 1'b0;
        w_hold_front    = 1'b0;
        w_bubble        = 1'b0;
        w_flush         = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (ldst_req && !ldst_resume) begin
                    w_hold_all      = 1'b1;
                    w_next_state    = ST_MEM_WAIT;
                    w_next_wait_cnt = '0;
                end else if (check_stall != 2'b00) begin
                    // Branch operands are stale under a load-use stall, so the redirect waits.
                    w_hold_front = 1'b1;
                    w_bubble     = 1'b1;
                end else if (idu_flush) begin
                    w_flush = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (ldst_resume) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_hold_all = 1'b1;
                    if (r_wait_cnt == WW'(WAIT_LIMIT - 1)) begin
                        w_next_state = ST_ERROR;
                    end else begin
                        w_next_wait_cnt = r_wait_cnt + WW'(1);
                    end
                end
            end
            ST_ERROR: begin
                w_hold_all = 1'b1;
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase
    end

    assign pc_hold     = brq_rst_n & (w_hold_all | w_hold_front);
    assign ifid_hold   = brq_rst_n & (w_hold_all | w_hold_front);
    assign idex_hold   = brq_rst_n & w_hold_all;
    assign exmem_hold  = brq_rst_n & w_hold_all;
    assign idex_bubble = brq_rst_n & w_bubble;
    assign ifid_flush  = brq_rst_n & w_flush;

    always_ff @(posedge brq_clk or negedge brq_rst_n) begin
        if (!brq_rst_n) begin
            r_state        <= ST_RUN;
            r_wait_cnt     <= '0;
            r_timeout      <= 1'b0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait_cnt;
            if (w_next_state == ST_ERROR) begin
                r_timeout <= 1'b1;
            end
            if (pc_hold && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
            end
            if (ifid_flush && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + CNT_WIDTH'(1);
            end
        end
    end

    assign hz_state     = r_state;
    assign hz_timeout   = r_timeout;
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb/tb_hazard_sequencer.sv - self-checking bench for hazard_sequencer
module tb_hazard_sequencer;

    localparam int CW   = 4;
    localparam int WL   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          brq_clk = 1'b0;
    logic          brq_rst_n;
    logic [1:0]    check_stall = 2'b00;
    logic          idu_flush = 1'b0;
    logic          ldst_req = 1'b0;
    logic          ldst_resume = 1'b0;
    logic          pc_hold, ifid_hold, idex_hold, exmem_hold, idex_bubble, ifid_flush;
    logic [1:0]    hz_state;
    logic          hz_timeout;
    logic [CW-1:0] stall_cycles, flush_count;

    hazard_sequencer #(.CNT_WIDTH(CW), .WAIT_LIMIT(WL)) dut (
        .brq_clk      (brq_clk),
        .brq_rst_n    (brq_rst_n),
        .check_stall  (check_stall),
        .idu_flush    (idu_flush),
        .ldst_req     (ldst_req),
        .ldst_resume  (ldst_resume),
        .pc_hold      (pc_hold),
        .ifid_hold    (ifid_hold),
        .idex_hold    (idex_hold),
        .exmem_hold   (exmem_hold),
        .idex_bubble  (idex_bubble),
        .ifid_flush   (ifid_flush),
        .hz_state     (hz_state),
        .hz_timeout   (hz_timeout),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    always #5 brq_clk = ~brq_clk;

    int checks   = 0;
    int failures = 0;

    // Reference: "waiting" with a count of unanswered wait cycles, and a sticky error.
    bit m_wait;
    int m_waited;
    bit m_err;
    int m_stall;
    int m_flush;

    typedef struct {
        logic [1:0] cs;
        logic       fl;
        logic       rq;
        logic       rs;
        logic [5:0] strb;   // pc, ifid, idex, exmem, bubble, flush
        logic [1:0] st;
        int         sc;
        int         fc;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] exp_strobes(input logic [1:0] cs, input logic fl,
                                               input logic rq, input logic rs);
        if (m_err) return 6'b111100;
        if (m_wait) return rs ? 6'b000000 : 6'b111100;
        if (rq && !rs) return 6'b111100;
        if (cs != 2'b00) return 6'b110010;
        if (fl) return 6'b000001;
        return 6'b000000;
    endfunction

    function automatic int exp_state();
        if (m_err) return 3;
        if (m_wait) return 1;
        return 0;
    endfunction

    task automatic model_update(input logic rq, input logic rs, input logic [5:0] e);
        if (e[5] && m_stall < CMAX) m_stall++;
        if (e[0] && m_flush < CMAX) m_flush++;
        if (m_err) begin
        end else if (m_wait) begin
            if (rs) m_wait = 0;
            else begin
                m_waited++;
                if (m_waited == WL) begin
                    m_err  = 1;
                    m_wait = 0;
                end
            end
        end else if (rq && !rs) begin
            m_wait   = 1;
            m_waited = 0;
        end
    endtask

    task automatic check_regs();
        chk("hz_state", hz_state, exp_state());
        chk("hz_timeout", hz_timeout, m_err);
        chk("stall_cycles", stall_cycles, m_stall);
        chk("flush_count", flush_count, m_flush);
    endtask

    task automatic step(input logic [1:0] cs, input logic fl, input logic rq, input logic rs,
                        output logic [5:0] s);
        logic [5:0] e;
        check_stall = cs;
        idu_flush   = fl;
        ldst_req    = rq;
        ldst_resume = rs;
        e = exp_strobes(cs, fl, rq, rs);
        @(negedge brq_clk);
        s = {pc_hold, ifid_hold, idex_hold, exmem_hold, idex_bubble, ifid_flush};
        chk("strobes", s, e);
        @(posedge brq_clk);
        #1;
        model_update(rq, rs, e);
        check_regs();
    endtask

    // Asserted away from the edge; registers must clear at once and strobes stay low.
    task automatic do_reset();
        brq_rst_n   = 1'b0;
        check_stall = 2'b01;
        idu_flush   = 1'b1;
        ldst_req    = 1'b1;
        ldst_resume = 1'b0;
        #2;
        chk("reset_strobes", {pc_hold, ifid_hold, idex_hold, exmem_hold, idex_bubble, ifid_flush}, 0);
        m_wait = 0; m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0;
        check_regs();
        @(posedge brq_clk);
        #1;
        brq_rst_n = 1'b1;
    endtask

    vec_t       vecs[11];
    logic [5:0] s;

    initial begin
        vecs[0]  = '{2'b01, 1'b1, 1'b0, 1'b0, 6'b110010, 2'b00, 1, 0};
        vecs[1]  = '{2'b00, 1'b0, 1'b0, 1'b0, 6'b000000, 2'b00, 1, 0};
        vecs[2]  = '{2'b00, 1'b1, 1'b0, 1'b0, 6'b000001, 2'b00, 1, 1};
        vecs[3]  = '{2'b00, 1'b1, 1'b0, 1'b0, 6'b000001, 2'b00, 1, 2};
        vecs[4]  = '{2'b00, 1'b0, 1'b1, 1'b0, 6'b111100, 2'b01, 2, 2};
        vecs[5]  = '{2'b00, 1'b0, 1'b0, 1'b0, 6'b111100, 2'b01, 3, 2};
        vecs[6]  = '{2'b01, 1'b1, 1'b1, 1'b0, 6'b111100, 2'b01, 4, 2};
        vecs[7]  = '{2'b10, 1'b1, 1'b0, 1'b1, 6'b000000, 2'b00, 4, 2};
        vecs[8]  = '{2'b10, 1'b0, 1'b1, 1'b1, 6'b110010, 2'b00, 5, 2};
        vecs[9]  = '{2'b00, 1'b1, 1'b1, 1'b1, 6'b000001, 2'b00, 5, 3};
        vecs[10] = '{2'b11, 1'b0, 1'b0, 1'b0, 6'b110010, 2'b00, 6, 3};

        brq_rst_n = 1'b1;
        #1;
        do_reset();

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].cs, vecs[i].fl, vecs[i].rq, vecs[i].rs, s);
            chk($sformatf("vec%0d_strobes", i), s, vecs[i].strb);
            chk($sformatf("vec%0d_state", i), hz_state, vecs[i].st);
            chk($sformatf("vec%0d_stall", i), stall_cycles, vecs[i].sc);
            chk($sformatf("vec%0d_flush", i), flush_count, vecs[i].fc);
        end

        // Watchdog: one RUN cycle plus WL unanswered MEM_WAIT cycles.
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            step(2'b00, 1'b0, 1'b1, 1'b0, s);
            if (i == 4) chk("wd_state_before", hz_state, 1);
            if (i == 4) chk("wd_timeout_before", hz_timeout, 0);
        end
        chk("wd_state", hz_state, 3);
        chk("wd_timeout", hz_timeout, 1);
        step(2'b00, 1'b0, 1'b0, 1'b1, s);
        chk("err_resume_strobes", s, 6'b111100);
        chk("err_resume_state", hz_state, 3);
        chk("err_stall", stall_cycles, 6);
        do_reset();
        chk("post_reset_state", hz_state, 0);
        chk("post_reset_timeout", hz_timeout, 0);

        // Saturation of a 4-bit counter.
        for (int i = 1; i <= 20; i++) begin
            step(2'b01, 1'b0, 1'b0, 1'b0, s);
            if (i == 14) chk("sat_14", stall_cycles, 14);
        end
        chk("sat_final", stall_cycles, 15);

        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic [1:0] cs;
            logic       fl, rq, rs;
            if ($urandom_range(0, 99) < 3) begin
                do_reset();
            end else begin
                cs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                fl = ($urandom_range(0, 2) == 0);
                rq = ($urandom_range(0, 9) < 3);
                rs = ($urandom_range(0, 3) == 0);
                step(cs, fl, rq, rs, s);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
